// File: rtl/pipelined_control_unit_if.sv
// ID-stage instruction handshake between fetch (IF/ID register) and the
// pipelined control unit.
//   instr_valid   fetch -> control : an instruction is present in ID
//   instruction   fetch -> control : the 32-bit ID-stage instruction
//   decode_ready  control -> fetch : the ID instruction is taken at this edge
interface pipelined_control_unit_if;
  logic        instr_valid;
  logic [31:0] instruction;
  logic        decode_ready;

  modport master (output instr_valid, output instruction, input decode_ready);
  modport slave  (input instr_valid, input instruction, output decode_ready);
endinterface

// File: rtl/pipelined_control_unit.sv
// Pipelined control unit: decodes an ARM-style instruction in ID and carries
// the control bundle through EX, MEM and WB.  Provides conditional execution
// against a registered NZCV register, load-use and flag-use interlocks,
// branch flush and an external stall.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   id (slave)         instr_valid / instruction in, decode_ready out
//   stall              freezes EX, MEM, WB and flags
//   alu_flags          {N,Z,C,V} from the EX-stage ALU
//   flush              taken branch in EX
//   flags              committed NZCV
//   ex_* / mem_* / wb_* per-stage control outputs (all 0 for bubbles)
module pipelined_control_unit #(
  parameter bit COND_EXEC     = 1'b1,
  parameter bit HAZARD_DETECT = 1'b1,
  parameter int REG_ADDR_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pipelined_control_unit_if.slave id,
  input  logic                    stall,
  input  logic [3:0]              alu_flags,
  output logic                    flush,
  output logic [3:0]              flags,
  output logic [3:0]              ex_alu_operation,
  output logic                    ex_alu_source_select,
  output logic                    ex_status_bit,
  output logic [1:0]              ex_addressing_mode,
  output logic                    ex_pc_source_select,
  output logic                    mem_enable,
  output logic                    mem_rw,
  output logic                    mem_size,
  output logic                    mem_to_reg_select,
  output logic                    wb_reg_write_enable,
  output logic [REG_ADDR_W-1:0]   wb_rd
);
  localparam logic [3:0] COND_AL = 4'b1110;

  typedef struct packed {
    logic                  valid;
    logic [3:0]            cond;
    logic [3:0]            alu_op;
    logic                  alu_src;
    logic                  status;
    logic [1:0]            amode;
    logic                  pc_src;
    logic                  mem_en;
    logic                  mem_rw;
    logic                  mem_size;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
  } ex_ctrl_t;

  typedef struct packed {
    logic                  mem_en;
    logic                  mem_rw;
    logic                  mem_size;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
  } mem_ctrl_t;

  typedef struct packed {
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
  } wb_ctrl_t;

  function automatic logic [3:0] alu_map(input logic [3:0] opcode);
    logic [3:0] op;
    case (opcode)
      4'b0000, 4'b1000: op = 4'b0110; // AND / TST
      4'b0001, 4'b1001: op = 4'b1000; // EOR / TEQ
      4'b0010, 4'b1010: op = 4'b0010; // SUB / CMP
      4'b0011:          op = 4'b0100; // RSB
      4'b0100, 4'b1011: op = 4'b0000; // ADD / CMN
      4'b0101:          op = 4'b0001; // ADC
      4'b0110:          op = 4'b0011; // SBC
      4'b0111:          op = 4'b0101; // RSC
      4'b1100:          op = 4'b0111; // ORR
      4'b1101:          op = 4'b1010; // MOV
      4'b1110:          op = 4'b1100; // BIC
      default:          op = 4'b1011; // MVN
    endcase
    return op;
  endfunction

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, ok;
    {n, z, c, v} = nzcv;
    case (cond)
      4'b0000: ok = z;
      4'b0001: ok = !z;
      4'b0010: ok = c;
      4'b0011: ok = !c;
      4'b0100: ok = n;
      4'b0101: ok = !n;
      4'b0110: ok = v;
      4'b0111: ok = !v;
      4'b1000: ok = c && !z;
      4'b1001: ok = !c || z;
      4'b1010: ok = (n == v);
      4'b1011: ok = (n != v);
      4'b1100: ok = !z && (n == v);
      4'b1101: ok = z || (n != v);
      4'b1110: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic [31:0] ins;
  ex_ctrl_t    id_ctrl, ex_q;
  mem_ctrl_t   mem_d, mem_q;
  wb_ctrl_t    wb_q;
  logic        use_rn, use_rm, use_rd;
  logic        ex_live, load_use, flag_use, interlock;
  logic [3:0]  flags_q;

  assign ins = id.instruction;

  // ID decode; source-register usage feeds the load-use compare
  always_comb begin
    id_ctrl = '0;
    use_rn  = 1'b0;
    use_rm  = 1'b0;
    use_rd  = 1'b0;
    if (id.instr_valid && ins != 32'd0 && ins[27:26] != 2'b11) begin
      id_ctrl.valid = 1'b1;
      id_ctrl.cond  = COND_EXEC ? ins[31:28] : COND_AL;
      case (ins[27:26])
        2'b00: begin
          id_ctrl.alu_op    = alu_map(ins[24:21]);
          id_ctrl.status    = ins[20];
          // TST/TEQ/CMP/CMN occupy opcodes 10xx and only set flags
          id_ctrl.reg_write = (ins[24:23] != 2'b10);
          id_ctrl.amode     = ins[25] ? 2'b00 : ((ins[11:4] != 8'd0) ? 2'b11 : 2'b01);
          if (ins[24:23] != 2'b10) id_ctrl.rd = ins[12 +: REG_ADDR_W];
          use_rn = (ins[24:21] != 4'b1101) && (ins[24:21] != 4'b1111);
          use_rm = !ins[25];
        end
        2'b01: begin
          id_ctrl.mem_en   = 1'b1;
          id_ctrl.alu_src  = 1'b1;
          id_ctrl.mem_size = !ins[22];
          if (ins[20]) begin
            id_ctrl.reg_write  = 1'b1;
            id_ctrl.mem_to_reg = 1'b1;
            id_ctrl.amode      = 2'b11;
            id_ctrl.rd         = ins[12 +: REG_ADDR_W];
          end else begin
            id_ctrl.mem_rw = 1'b1;
            id_ctrl.amode  = 2'b10;
          end
          use_rn = 1'b1;
          use_rm = ins[25];
          use_rd = !ins[20];
        end
        default: id_ctrl.pc_src = 1'b1;
      endcase
    end
  end

  assign ex_live = ex_q.valid && cond_pass(ex_q.cond, flags_q);
  assign flush   = ex_live && ex_q.pc_src;

  // a load in EX always has reg_write set, so ex_q.rd is its destination
  assign load_use = ex_q.valid && ex_q.mem_to_reg && id_ctrl.valid &&
                    ((use_rn && ins[16 +: REG_ADDR_W] == ex_q.rd) ||
                     (use_rm && ins[0 +: REG_ADDR_W] == ex_q.rd) ||
                     (use_rd && ins[12 +: REG_ADDR_W] == ex_q.rd));
  assign flag_use = COND_EXEC && ex_q.valid && ex_q.status && id_ctrl.valid &&
                    (id_ctrl.cond != COND_AL);
  assign interlock = HAZARD_DETECT && (load_use || flag_use);

  assign id.decode_ready = !stall && !flush && !interlock;

  // a condition-failed instruction enters MEM as a bubble
  always_comb begin
    mem_d = '0;
    if (ex_live) begin
      mem_d.mem_en     = ex_q.mem_en;
      mem_d.mem_rw     = ex_q.mem_rw;
      mem_d.mem_size   = ex_q.mem_size;
      mem_d.mem_to_reg = ex_q.mem_to_reg;
      mem_d.reg_write  = ex_q.reg_write;
      mem_d.rd         = ex_q.rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      flags_q <= '0;
    end else if (!stall) begin
      ex_q          <= (flush || interlock) ? '0 : id_ctrl;
      mem_q         <= mem_d;
      wb_q.reg_write <= mem_q.reg_write;
      wb_q.rd       <= mem_q.rd;
      if (ex_live && ex_q.status) flags_q <= alu_flags;
    end
  end

  assign flags                = flags_q;
  assign ex_alu_operation     = ex_live ? ex_q.alu_op : 4'd0;
  assign ex_alu_source_select = ex_live && ex_q.alu_src;
  assign ex_status_bit        = ex_live && ex_q.status;
  assign ex_addressing_mode   = ex_live ? ex_q.amode : 2'd0;
  assign ex_pc_source_select  = ex_live && ex_q.pc_src;
  assign mem_enable           = mem_q.mem_en;
  assign mem_rw               = mem_q.mem_rw;
  assign mem_size             = mem_q.mem_size;
  assign mem_to_reg_select    = mem_q.mem_to_reg;
  // held WB entry must not write twice across a stall
  assign wb_reg_write_enable  = wb_q.reg_write && !stall;
  assign wb_rd                = wb_q.rd;
endmodule
